// File: rtl/pipeline_pkg.sv
// Shared ALU function encodings, datapath widths and the forwarding-source selector
// used by the ID/EX stage.
package pipeline_pkg;

  localparam int XLEN     = 32;
  localparam int REGW     = 5;
  localparam int STALL_CW = 16;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_XNOR = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of rs (EX > MEM > WB),
// falling back to regfile data. Register 0 is never forwarded.
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN,
  parameter int REGW = pipeline_pkg::REGW
) (
  input  logic [REGW-1:0] rs_i,
  input  logic            ex_fwd_en_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_we_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_we_i,
  input  logic [REGW-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic [XLEN-1:0] operand_o
);

  fwd_sel_e sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (ex_fwd_en_i && ex_rd_i != '0 && ex_rd_i == rs_i) begin
      sel = FWD_EX;
    end else if (mem_we_i && mem_rd_i != '0 && mem_rd_i == rs_i) begin
      sel = FWD_MEM;
    end else if (wb_we_i && wb_rd_i != '0 && wb_rd_i == rs_i) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    operand_o = rf_data_i;
    case (sel)
      FWD_EX:  operand_o = ex_data_i;
      FWD_MEM: operand_o = mem_data_i;
      FWD_WB:  operand_o = wb_data_i;
      default: operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: forwarded operand capture, load-use
// bubble insertion, backpressure/flush handling and a saturating stall counter.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN     = pipeline_pkg::XLEN,
  parameter int REGW     = pipeline_pkg::REGW,
  parameter int STALL_CW = pipeline_pkg::STALL_CW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [REGW-1:0]     id_rs1,
  input  logic [REGW-1:0]     id_rs2,
  input  logic [REGW-1:0]     id_rd,
  input  logic [XLEN-1:0]     id_rd1,
  input  logic [XLEN-1:0]     id_rd2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_use_imm,
  input  logic [3:0]          id_alu_func,
  input  logic                id_mem_read,
  input  logic                id_reg_write,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                mem_reg_write,
  input  logic [REGW-1:0]     mem_rd,
  input  logic [XLEN-1:0]     mem_result,
  input  logic                wb_reg_write,
  input  logic [REGW-1:0]     wb_rd,
  input  logic [XLEN-1:0]     wb_result,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_In1,
  output logic [XLEN-1:0]     ex_In2,
  output logic [3:0]          ex_alu_func,
  output logic [REGW-1:0]     ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic [STALL_CW-1:0] stall_cnt
);

  logic                ex_valid_q, ex_reg_write_q, ex_mem_read_q;
  logic [XLEN-1:0]     ex_in1_q, ex_in2_q;
  logic [3:0]          ex_alu_func_q;
  logic [REGW-1:0]     ex_rd_q;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

  logic            advance, hazard, capture, ex_fwd_en;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign advance   = !ex_valid_q || ex_ready;
  assign hazard    = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && id_valid &&
                     ((id_rs1 == ex_rd_q) || (!id_use_imm && (id_rs2 == ex_rd_q)));
  assign id_ready  = flush || (advance && !hazard);
  assign capture   = !flush && advance && id_valid && !hazard;
  // A load in EX has no data yet; its consumers are caught by the hazard instead.
  assign ex_fwd_en = ex_valid_q && ex_reg_write_q && !ex_mem_read_q;

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs_i        (id_rs1),
    .ex_fwd_en_i (ex_fwd_en),
    .ex_rd_i     (ex_rd_q),
    .ex_data_i   (alu_result),
    .mem_we_i    (mem_reg_write),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_result),
    .wb_we_i     (wb_reg_write),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_result),
    .rf_data_i   (id_rd1),
    .operand_o   (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs_i        (id_rs2),
    .ex_fwd_en_i (ex_fwd_en),
    .ex_rd_i     (ex_rd_q),
    .ex_data_i   (alu_result),
    .mem_we_i    (mem_reg_write),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_result),
    .wb_we_i     (wb_reg_write),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_result),
    .rf_data_i   (id_rd2),
    .operand_o   (fwd_rs2)
  );

  // NOTE: the payload is reset too, because every EX output must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ex_valid_q     <= 1'b0;
      ex_in1_q       <= '0;
      ex_in2_q       <= '0;
      ex_alu_func_q  <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= capture;
      if (capture) begin
        ex_in1_q       <= fwd_rs1;
        ex_in2_q       <= id_use_imm ? id_imm : fwd_rs2;
        ex_alu_func_q  <= id_alu_func;
        ex_rd_q        <= id_rd;
        ex_reg_write_q <= id_reg_write;
        ex_mem_read_q  <= id_mem_read;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign ex_valid     = ex_valid_q;
  assign ex_In1       = ex_in1_q;
  assign ex_In2       = ex_in2_q;
  assign ex_alu_func  = ex_alu_func_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued as stimulus is
// driven and compared one cycle later; stall counter and handshakes checked inline.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int XW  = 32;
  localparam int RW  = 5;
  localparam int SCW = 4;

  typedef struct packed {
    logic          v;
    logic [XW-1:0] in1;
    logic [XW-1:0] in2;
    logic [3:0]    func;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } ex_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid, id_ready, id_use_imm, id_mem_read, id_reg_write;
  logic [RW-1:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [XW-1:0]  id_rd1, id_rd2, id_imm, alu_result, mem_result, wb_result;
  logic [3:0]     id_alu_func, ex_alu_func;
  logic           mem_reg_write, wb_reg_write, flush, ex_ready;
  logic           ex_valid, ex_reg_write, ex_mem_read;
  logic [XW-1:0]  ex_In1, ex_In2;
  logic [SCW-1:0] stall_cnt;

  ex_t exp_q[$];
  ex_t last_exp, got, e;
  int  errors = 0;
  int  checks = 0;
  int  exp_stall = 0;

  id_ex_stage #(.XLEN(XW), .REGW(RW), .STALL_CW(SCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_alu_func(id_alu_func), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .alu_result(alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_In1(ex_In1), .ex_In2(ex_In2), .ex_alu_func(ex_alu_func),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic ex_t snap();
    snap = {ex_valid, ex_In1, ex_In2, ex_alu_func, ex_rd, ex_reg_write, ex_mem_read};
  endfunction

  function automatic ex_t mk(input logic v, input logic [XW-1:0] a, input logic [XW-1:0] b,
                             input logic [3:0] f, input logic [RW-1:0] rd,
                             input logic rw, input logic mr);
    mk = {v, a, b, f, rd, rw, mr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ex_t x);
    exp_q.push_back(x);
    last_exp = x;
  endtask

  task automatic clr_src();
    alu_result = '0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0;  wb_rd = '0;  wb_result = '0;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_use_imm = 1'b0;
    id_alu_func = '0; id_mem_read = 1'b0; id_reg_write = 1'b0;
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic issue(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic [XW-1:0] rd1,
                       input logic [XW-1:0] rd2, input logic [XW-1:0] imm,
                       input logic use_imm, input logic [3:0] f,
                       input logic mr, input logic rw);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_use_imm = use_imm;
    id_alu_func = f; id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    clr_src();
    #2;
    checks++;
    if (snap() !== ex_t'(0)) begin
      errors++; $display("FAIL reset_ex got=%h exp=0", snap());
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
    end
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL reset_id_ready got=%b exp=1", id_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ex_forward();
    issue(1, 2, 3, 32'd10, 32'd20, '0, 1'b0, ALU_ADD, 1'b0, 1'b1);
    push(mk(1'b1, 32'd10, 32'd20, ALU_ADD, 3, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t1_add got=%h exp=%h", got, e); end

    alu_result = 32'h7;
    issue(3, 5, 4, 32'h111, 32'h55, '0, 1'b0, ALU_AND, 1'b0, 1'b1);
    push(mk(1'b1, 32'h7, 32'h55, ALU_AND, 4, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t1_and_exfwd got=%h exp=%h", got, e); end

    alu_result = 32'h99;
    issue(4, 4, 8, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, ALU_SUB, 1'b0, 1'b1);
    push(mk(1'b1, 32'h99, 32'hFFFF_FFF0, ALU_SUB, 8, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t1_sub_imm got=%h exp=%h", got, e); end

    alu_result = 32'h0;
    issue(2, 1, 11, 32'h30, 32'h40, '0, 1'b0, ALU_SLT, 1'b0, 1'b0);
    push(mk(1'b1, 32'h30, 32'h40, ALU_SLT, 11, 1'b0, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t1_slt got=%h exp=%h", got, e); end
  endtask

  task automatic test_load_use();
    issue(1, 0, 6, 32'h1000, '0, 32'd4, 1'b1, ALU_ADD, 1'b1, 1'b1);
    push(mk(1'b1, 32'h1000, 32'd4, ALU_ADD, 6, 1'b1, 1'b1));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t2_lw got=%h exp=%h", got, e); end

    issue(6, 1, 7, 32'hBAD, 32'h22, '0, 1'b0, ALU_ADD, 1'b0, 1'b1);
    #1; checks++;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL t2_hazard_ready got=%b exp=0", id_ready); end
    e = last_exp; e.v = 1'b0; push(e);
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t2_bubble got=%h exp=%h", got, e); end
    exp_stall = 1; checks++;
    if (stall_cnt !== SCW'(exp_stall)) begin
      errors++; $display("FAIL t2_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end

    mem_reg_write = 1'b1; mem_rd = 6; mem_result = 32'hDEAD_BEEF;
    #1; checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL t2_resume_ready got=%b exp=1", id_ready); end
    push(mk(1'b1, 32'hDEAD_BEEF, 32'h22, ALU_ADD, 7, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t2_memfwd got=%h exp=%h", got, e); end
    clr_src();
  endtask

  task automatic test_priority();
    issue(0, 0, 9, '0, '0, '0, 1'b0, ALU_ADD, 1'b0, 1'b1);
    push(mk(1'b1, '0, '0, ALU_ADD, 9, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t3_prod_r9 got=%h exp=%h", got, e); end

    alu_result = 32'h1;
    mem_reg_write = 1'b1; mem_rd = 9; mem_result = 32'h2;
    wb_reg_write = 1'b1;  wb_rd = 9;  wb_result = 32'h3;
    issue(9, 9, 10, 32'hAA, 32'hBB, '0, 1'b0, ALU_XOR, 1'b0, 1'b1);
    push(mk(1'b1, 32'h1, 32'h1, ALU_XOR, 10, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t3_ex_first got=%h exp=%h", got, e); end

    wb_rd = 13;
    issue(9, 13, 12, 32'hAA, 32'hBB, '0, 1'b0, ALU_OR, 1'b0, 1'b1);
    push(mk(1'b1, 32'h2, 32'h3, ALU_OR, 12, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t3_mem_wb got=%h exp=%h", got, e); end

    issue(0, 0, 0, '0, '0, '0, 1'b0, ALU_XNOR, 1'b0, 1'b1);
    push(mk(1'b1, '0, '0, ALU_XNOR, 0, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t3_prod_r0 got=%h exp=%h", got, e); end

    alu_result = 32'h5;
    mem_rd = 0; mem_result = 32'h6;
    wb_rd = 0;  wb_result = 32'h7;
    issue(0, 0, 14, '0, '0, '0, 1'b0, ALU_ADD, 1'b0, 1'b1);
    push(mk(1'b1, '0, '0, ALU_ADD, 14, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t3_rd0 got=%h exp=%h", got, e); end
    clr_src();
  endtask

  task automatic test_backpressure();
    issue(1, 2, 15, 32'h123, 32'h456, '0, 1'b0, ALU_SUB, 1'b0, 1'b1);
    ex_ready = 1'b0;
    #1; checks++;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_low got=%b exp=0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      push(last_exp);
      tick(); got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL t4_hold%0d got=%h exp=%h", i, got, e); end
    end
    exp_stall += 3; checks++;
    if (stall_cnt !== SCW'(exp_stall)) begin
      errors++; $display("FAIL t4_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    ex_ready = 1'b1;
    #1; checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_high got=%b exp=1", id_ready); end
    push(mk(1'b1, 32'h123, 32'h456, ALU_SUB, 15, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t4_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_flush();
    issue(1, 0, 16, 32'h2000, '0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b1);
    push(mk(1'b1, 32'h2000, 32'd8, ALU_ADD, 16, 1'b1, 1'b1));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t5_lw got=%h exp=%h", got, e); end

    issue(16, 2, 17, 32'h1, 32'h2, '0, 1'b0, ALU_ADD, 1'b0, 1'b1);
    flush = 1'b1;
    #1; checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL t5_flush_ready got=%b exp=1", id_ready); end
    e = last_exp; e.v = 1'b0; push(e);
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL t5_flushed got=%h exp=%h", got, e); end
    checks++;
    if (stall_cnt !== SCW'(exp_stall)) begin
      errors++; $display("FAIL t5_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    idle();
  endtask

  task automatic test_stall_saturate();
    issue(1, 2, 18, 32'h5, 32'h6, '0, 1'b0, ALU_AND, 1'b0, 1'b1);
    push(mk(1'b1, 32'h5, 32'h6, ALU_AND, 18, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sat_capture got=%h exp=%h", got, e); end

    ex_ready = 1'b0;
    repeat (20) tick();
    exp_stall = (exp_stall + 20 > 15) ? 15 : exp_stall + 20;
    checks++;
    if (stall_cnt !== SCW'(exp_stall)) begin
      errors++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    push(last_exp);
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sat_hold got=%h exp=%h", got, e); end

    ex_ready = 1'b1;
    push(mk(1'b1, 32'h5, 32'h6, ALU_AND, 18, 1'b1, 1'b0));
    tick(); got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL sat_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    @(posedge clk);
    #3; checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL t6_pre_valid got=%b exp=1", ex_valid); end
    rst_n = 1'b0;
    #1; checks++;
    if (snap() !== ex_t'(0)) begin
      errors++; $display("FAIL t6_async_ex got=%h exp=0", snap());
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL t6_async_stall got=%0d exp=0", stall_cnt);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_priority();
    test_backpressure();
    test_flush();
    test_stall_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
